// File: rtl/sop_sched_pkg.sv
// Shared state encoding, operand widths and job limits for the sum-of-products scheduler.
package sop_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int X_W        = 18;
  localparam int Y_W        = 19;
  localparam int SOP_RES_W  = 37;
  localparam int BEAT_LIMIT = 2048;
  localparam int BEAT_CNT_W = 12;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sop_rr_arb.sv
// Round-robin pick: the first active requester after i_last_grant, wrapping around.
module sop_rr_arb
  import sop_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(i_last_grant) + k) % N_REQ);
      if (i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sop_scheduler.sv
// Time-shares one int_sop_2 multiply-add between N_REQ requesters, accumulating one
// dot-product job at a time and returning the sum tagged with its requester index.
module sop_scheduler
  import sop_sched_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int SOP_LAT = 3,
  parameter  int ACC_W   = 48,
  localparam int IDX_W   = idx_width(N_REQ)
) (
  input  logic                   clk0,
  input  logic                   aclr0_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*X_W-1:0]   req_ax,
  input  logic [N_REQ*X_W-1:0]   req_bx,
  input  logic [N_REQ*Y_W-1:0]   req_ay,
  input  logic [N_REQ*Y_W-1:0]   req_by,
  output logic [X_W-1:0]         sop_ax,
  output logic [X_W-1:0]         sop_bx,
  output logic [Y_W-1:0]         sop_ay,
  output logic [Y_W-1:0]         sop_by,
  output logic [63:0]            sop_chainin,
  output logic [2:0]             sop_ena,
  output logic                   sop_aclr,
  input  logic [SOP_RES_W-1:0]   sop_resulta,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       res_data,
  output logic [IDX_W-1:0]       res_tag,
  output logic                   res_ovf,
  output logic                   busy
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_last_grant;
  logic [IDX_W-1:0]        r_grant;
  logic [SOP_LAT-1:0]      r_shadow;
  logic signed [ACC_W-1:0] r_acc;
  logic [BEAT_CNT_W-1:0]   r_beats;
  logic                    r_ovf;
  logic                    r_res_valid;
  logic [ACC_W-1:0]        r_res_data;
  logic [IDX_W-1:0]        r_res_tag;
  logic                    r_res_ovf;

  logic [N_REQ-1:0]        w_arb_grant;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_any;
  logic [N_REQ-1:0]        w_ready;
  logic                    w_accept;
  logic                    w_grant_load;
  logic                    w_res_load;
  logic                    w_res_hs;

  sop_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_idx        (w_arb_idx),
    .o_any        (w_arb_any)
  );

  always_ff @(posedge clk0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = '0;
    w_accept     = 1'b0;
    w_grant_load = 1'b0;
    w_res_load   = 1'b0;
    w_res_hs     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) begin
          w_grant_load = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_ready[r_grant] = 1'b1;
        w_accept         = req_valid[r_grant];
        if (w_accept && req_last[r_grant]) begin
          w_state_next = ST_DRAIN;
        end
      end
      // An empty shadow means the last in-flight product was folded in on the previous edge.
      ST_DRAIN: begin
        if (r_shadow == '0) begin
          w_res_load   = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          w_res_hs     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sop_ax = '0;
    sop_bx = '0;
    sop_ay = '0;
    sop_by = '0;
    if (w_accept) begin
      sop_ax = req_ax[r_grant*X_W +: X_W];
      sop_bx = req_bx[r_grant*X_W +: X_W];
      sop_ay = req_ay[r_grant*Y_W +: Y_W];
      sop_by = req_by[r_grant*Y_W +: Y_W];
    end
  end

  always_ff @(posedge clk0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_grant      <= '0;
      r_shadow     <= '0;
      r_acc        <= '0;
      r_beats      <= '0;
      r_ovf        <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_tag    <= '0;
      r_res_ovf    <= 1'b0;
    end else begin
      r_shadow <= SOP_LAT'({r_shadow, w_accept});
      if (w_grant_load) begin
        r_grant <= w_arb_idx;
        r_acc   <= '0;
        r_beats <= '0;
        r_ovf   <= 1'b0;
      end else if (r_shadow[SOP_LAT-1]) begin
        r_acc <= r_acc + ACC_W'($signed(sop_resulta));
      end
      // Count saturates at the limit; any further beat marks the job as overflowed.
      if (w_accept) begin
        if (r_beats == BEAT_CNT_W'(BEAT_LIMIT)) begin
          r_ovf <= 1'b1;
        end else begin
          r_beats <= r_beats + BEAT_CNT_W'(1);
        end
      end
      if (w_res_load) begin
        r_res_valid <= 1'b1;
        r_res_data  <= r_acc;
        r_res_tag   <= r_grant;
        r_res_ovf   <= r_ovf;
      end else if (w_res_hs) begin
        r_res_valid  <= 1'b0;
        r_last_grant <= r_grant;
      end
    end
  end

  assign req_ready   = w_ready;
  assign sop_chainin = '0;
  assign sop_ena     = aclr0_n ? 3'b111 : 3'b000;
  assign sop_aclr    = ~aclr0_n;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_tag     = r_res_tag;
  assign res_ovf     = r_res_ovf;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sop_scheduler.sv
// Bench for sop_scheduler: models int_sop_2 as a product delay line and predicts job
// sums and grant order from queues of issued beats.
module tb_sop_scheduler;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int AW  = 48;
  localparam int TW  = 2;

  logic            clk0    = 1'b0;
  logic            aclr0_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_last = '0;
  logic [N*18-1:0] req_ax = '0;
  logic [N*18-1:0] req_bx = '0;
  logic [N*19-1:0] req_ay = '0;
  logic [N*19-1:0] req_by = '0;
  logic [17:0]     sop_ax, sop_bx;
  logic [18:0]     sop_ay, sop_by;
  logic [63:0]     sop_chainin;
  logic [2:0]      sop_ena;
  logic            sop_aclr;
  logic [36:0]     sop_resulta;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [AW-1:0]   res_data;
  logic [TW-1:0]   res_tag;
  logic            res_ovf;
  logic            busy;

  always #5 clk0 = ~clk0;

  sop_scheduler #(.N_REQ(N), .SOP_LAT(LAT), .ACC_W(AW)) dut (
    .clk0        (clk0),
    .aclr0_n     (aclr0_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_last    (req_last),
    .req_ax      (req_ax),
    .req_bx      (req_bx),
    .req_ay      (req_ay),
    .req_by      (req_by),
    .sop_ax      (sop_ax),
    .sop_bx      (sop_bx),
    .sop_ay      (sop_ay),
    .sop_by      (sop_by),
    .sop_chainin (sop_chainin),
    .sop_ena     (sop_ena),
    .sop_aclr    (sop_aclr),
    .sop_resulta (sop_resulta),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  // int_sop_2 stand-in: result appears LAT cycles after the operands were presented.
  logic signed [36:0] pipe [LAT];
  always @(posedge clk0 or posedge sop_aclr) begin
    if (sop_aclr) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= $signed(sop_ax) * $signed(sop_ay) + $signed(sop_bx) * $signed(sop_by);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sop_resulta = pipe[LAT-1];

  typedef struct packed {
    logic [17:0] ax;
    logic [18:0] ay;
    logic [17:0] bx;
    logic [18:0] by;
    logic        last;
    logic [3:0]  gap;
  } beat_t;

  typedef struct packed {
    int     req;
    int     ax;
    int     ay;
    int     bx;
    int     by;
    int     gap;
    bit     last;
    longint exp_data;
  } row_t;

  beat_t         q [N][$];
  int            gap_cnt [N];
  int            last_g;
  int            exp_grant;
  logic [AW-1:0] exp_sum;
  int            exp_beats;
  int            res_log [$];
  logic [AW-1:0] last_data;
  int            last_tag;
  bit            last_ovf;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_beat(input int r, input int ax, input int ay, input int bx, input int by,
                          input int gap, input bit last);
    beat_t b;
    b.ax = 18'(ax); b.ay = 19'(ay); b.bx = 18'(bx); b.by = 19'(by);
    b.last = last; b.gap = 4'(gap);
    q[r].push_back(b);
  endtask

  function automatic int next_grant();
    for (int k = 1; k <= N; k++) begin
      int c = (last_g + k) % N;
      if (q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic reset_dut();
    aclr0_n   = 1'b0;
    req_valid = '1;
    req_last  = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk0);
    check_eq("rst_req_ready", longint'(req_ready), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_res_valid", longint'(res_valid), 0);
    check_eq("rst_res_data", longint'(res_data), 0);
    check_eq("rst_res_tag", longint'(res_tag), 0);
    check_eq("rst_res_ovf", longint'(res_ovf), 0);
    check_eq("rst_sop_aclr", longint'(sop_aclr), 1);
    req_valid = '0;
    res_ready = 1'b0;
    aclr0_n   = 1'b1;
    last_g    = N - 1;
    for (int r = 0; r < N; r++) q[r].delete();
    #1;
    check_eq("run_sop_aclr", longint'(sop_aclr), 0);
    check_eq("run_sop_ena", longint'(sop_ena), 7);
    check_eq("run_sop_chainin", longint'(sop_chainin), 0);
    @(negedge clk0);
  endtask

  // Drives every queued job to completion, checking operands, grants and results.
  task automatic run_engine(input int budget, input int hold);
    int            cyc, wait_cnt, tgt, acc_r;
    bit            held;
    logic [AW-1:0] held_data;
    logic [N-1:0]  gmask;
    longint        p;
    beat_t         b;
    cyc = 0; wait_cnt = 0; tgt = 0; held = 1'b0; held_data = '0;
    exp_grant = next_grant();
    exp_sum   = '0;
    exp_beats = 0;
    for (int r = 0; r < N; r++) gap_cnt[r] = 0;
    while (exp_grant >= 0 || held) begin
      if (cyc >= budget) begin
        n_checks++;
        n_errors++;
        $display("FAIL engine_timeout: ran %0d cycles, required completion within %0d", cyc, budget);
        for (int r = 0; r < N; r++) q[r].delete();
        break;
      end
      if (res_valid && !held) begin
        held      = 1'b1;
        held_data = res_data;
        wait_cnt  = 0;
        tgt       = (hold >= 0) ? hold : int'($urandom_range(0, 3));
      end
      res_ready = held ? (wait_cnt >= tgt) : 1'($urandom_range(0, 1));
      for (int r = 0; r < N; r++) begin
        if (gap_cnt[r] > 0 || q[r].size() == 0) begin
          if (gap_cnt[r] > 0) gap_cnt[r]--;
          req_valid[r] = 1'b0;
          req_last[r]  = 1'($urandom_range(0, 1));
          req_ax[r*18 +: 18] = 18'($urandom);
          req_bx[r*18 +: 18] = 18'($urandom);
          req_ay[r*19 +: 19] = 19'($urandom);
          req_by[r*19 +: 19] = 19'($urandom);
        end else begin
          b = q[r][0];
          req_valid[r] = 1'b1;
          req_last[r]  = b.last;
          req_ax[r*18 +: 18] = b.ax;
          req_bx[r*18 +: 18] = b.bx;
          req_ay[r*19 +: 19] = b.ay;
          req_by[r*19 +: 19] = b.by;
        end
      end
      #4;
      gmask = '0;
      if (!held && exp_grant >= 0) gmask[exp_grant] = 1'b1;
      check_eq("ready_mask", longint'(req_ready & ~gmask), 0);
      acc_r = -1;
      for (int r = 0; r < N; r++) if (req_valid[r] && req_ready[r]) acc_r = r;
      if (acc_r >= 0) begin
        b = q[acc_r].pop_front();
        check_eq("sop_ax", longint'($signed(sop_ax)), longint'($signed(b.ax)));
        check_eq("sop_ay", longint'($signed(sop_ay)), longint'($signed(b.ay)));
        check_eq("sop_bx", longint'($signed(sop_bx)), longint'($signed(b.bx)));
        check_eq("sop_by", longint'($signed(sop_by)), longint'($signed(b.by)));
        p = longint'($signed(b.ax)) * longint'($signed(b.ay))
          + longint'($signed(b.bx)) * longint'($signed(b.by));
        exp_sum = exp_sum + AW'(p);
        exp_beats++;
        if (q[acc_r].size() > 0) gap_cnt[acc_r] = int'(q[acc_r][0].gap);
      end else begin
        check_eq("sop_idle_operands", longint'(|{sop_ax, sop_ay, sop_bx, sop_by}), 0);
      end
      if (held) begin
        check_eq("done_busy", longint'(busy), 1);
        if (wait_cnt > 0) check_eq("done_data_stable", longint'(res_data), longint'(held_data));
        if (res_ready) begin
          check_eq("res_tag", longint'(res_tag), longint'(exp_grant));
          check_eq("res_data", longint'(res_data), longint'(exp_sum));
          check_eq("res_ovf", longint'(res_ovf), longint'(exp_beats > 2048));
          $display("result tag=%0d beats=%0d data=%0d ovf=%0d", res_tag, exp_beats,
                   $signed(res_data), res_ovf);
          res_log.push_back(int'(res_tag));
          last_data = res_data;
          last_tag  = int'(res_tag);
          last_ovf  = res_ovf;
          last_g    = exp_grant;
          exp_sum   = '0;
          exp_beats = 0;
          held      = 1'b0;
          exp_grant = next_grant();
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk0);
      @(negedge clk0);
      cyc++;
    end
    req_valid = '0;
    res_ready = 1'b0;
  endtask

  row_t          tbl [9];
  int            exp_order [5];
  logic [AW-1:0] e48;

  initial begin
    tbl[0] = '{0, 1, 2, 3, 4, 0, 1'b0, 64'sd0};
    tbl[1] = '{0, 5, 6, 7, 8, 0, 1'b0, 64'sd0};
    tbl[2] = '{0, -1, 1, 0, 0, 0, 1'b1, 64'sd99};
    tbl[3] = '{1, 100, -3, 2, 2, 0, 1'b0, 64'sd0};
    tbl[4] = '{1, 0, 0, -7, 7, 0, 1'b1, -64'sd345};
    tbl[5] = '{2, -131072, -262144, 0, 0, 0, 1'b1, 64'sd34359738368};
    tbl[6] = '{3, 3, 3, 3, 3, 0, 1'b1, 64'sd18};
    tbl[7] = '{1, 2, 5, 1, 1, 0, 1'b0, 64'sd0};
    tbl[8] = '{1, -4, 2, 3, 3, 4, 1'b1, 64'sd12};
    exp_order = '{0, 1, 2, 3, 0};

    #2;
    reset_dut();

    // directed jobs, one at a time
    for (int i = 0; i < 9; i++) begin
      add_beat(tbl[i].req, tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].gap, tbl[i].last);
      if (tbl[i].last) begin
        run_engine(200, 0);
        e48 = AW'(tbl[i].exp_data);
        check_eq("tbl_data", longint'(last_data), longint'(e48));
        check_eq("tbl_tag", longint'(last_tag), longint'(tbl[i].req));
      end
    end

    // everyone requesting from reset, requester 0 with a second job queued
    reset_dut();
    res_log.delete();
    for (int r = 0; r < N; r++) begin
      add_beat(r, r + 1, 2, 3, -(r + 1), 0, 1'b0);
      add_beat(r, 7, r, 1, 1, 0, 1'b1);
    end
    add_beat(0, 9, 9, 9, 9, 0, 1'b1);
    run_engine(400, -1);
    check_eq("order_len", longint'(res_log.size()), 5);
    for (int i = 0; i < 5 && i < res_log.size(); i++) check_eq("order", res_log[i], exp_order[i]);

    // result held back for 10 cycles with another requester waiting
    add_beat(3, 11, -2, 4, 4, 0, 1'b0);
    add_beat(3, -6, 6, 1, 0, 0, 1'b1);
    add_beat(2, 1, 1, 1, 1, 0, 1'b1);
    run_engine(400, 10);

    // reset in the middle of a job
    reset_dut();
    req_valid = 4'b0100;
    req_last  = '0;
    req_ax[36 +: 18] = 18'd5;
    req_bx[36 +: 18] = 18'd5;
    req_ay[38 +: 19] = 19'd5;
    req_by[38 +: 19] = 19'd5;
    repeat (4) @(negedge clk0);
    check_eq("midjob_ready", longint'(req_ready), 4);
    check_eq("midjob_busy", longint'(busy), 1);
    #2 aclr0_n = 1'b0;
    #1;
    check_eq("pulse_req_ready", longint'(req_ready), 0);
    check_eq("pulse_busy", longint'(busy), 0);
    check_eq("pulse_res_valid", longint'(res_valid), 0);
    check_eq("pulse_res_data", longint'(res_data), 0);
    check_eq("pulse_sop_aclr", longint'(sop_aclr), 1);
    check_eq("pulse_sop_ax", longint'(sop_ax), 0);
    @(negedge clk0);
    req_valid = '0;
    aclr0_n   = 1'b1;
    last_g    = N - 1;
    #1;
    check_eq("release_sop_aclr", longint'(sop_aclr), 0);
    @(negedge clk0);
    for (int i = 0; i < 3; i++)
      add_beat(tbl[i].req, tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].gap, tbl[i].last);
    run_engine(200, 0);
    check_eq("post_reset_data", longint'(last_data), 99);
    check_eq("post_reset_tag", longint'(last_tag), 0);

    // random mixed traffic
    for (int round = 0; round < 3; round++) begin
      for (int r = 0; r < N; r++) begin
        int nj = $urandom_range(0, 2);
        for (int j = 0; j < nj; j++) begin
          int len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++)
            add_beat(r, $urandom, $urandom, $urandom, $urandom,
                     (k == 0) ? 0 : int'($urandom_range(0, 2)), k == len - 1);
        end
      end
      run_engine(2000, -1);
    end

    // beat-limit boundary: exactly 2048 beats, then 2049
    for (int k = 0; k < 2048; k++) add_beat(1, 131071, 262143, 131071, 262143, 0, k == 2047);
    run_engine(5000, 0);
    check_eq("limit_2048_ovf", longint'(last_ovf), 0);
    for (int k = 0; k < 2049; k++) add_beat(0, 131071, 262143, 131071, 262143, 0, k == 2048);
    run_engine(5000, 0);
    check_eq("limit_2049_ovf", longint'(last_ovf), 1);
    e48 = AW'(64'sd68718690306 * 64'sd2049);
    check_eq("limit_2049_data", longint'(last_data), longint'(e48));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sop_scheduler.md
SOP_SCHEDULER -- requirements
Module: sop_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one int_sop_2 instance.
REQ-002 Parameter SOP_LAT, default 3: cycles from operand drive to matching sop_resulta.
REQ-003 Parameter ACC_W, default 48: accumulator and result width.
REQ-004 Ports, as name, direction, width, meaning:
- clk0  in  1  sole clock; one clock, all logic rising-edge.
- aclr0_n  in  1  reset; asynchronous, active-low.
- req_valid  in  N_REQ  per-requester operand beat valid.
- req_ready  out  N_REQ  per-requester beat accept.
- req_last  in  N_REQ  marks the final beat of a job.
- req_ax, req_bx  in  N_REQ*18  flattened signed 18-bit operands.
- req_ay, req_by  in  N_REQ*19  flattened signed 19-bit operands.
- sop_ax, sop_bx  out  18  operands to int_sop_2.
- sop_ay, sop_by  out  19  operands to int_sop_2.
- sop_chainin  out  64  constant zero.
- sop_ena  out  3  clock enables.
- sop_aclr  out  1  active-high clear to int_sop_2 aclr0/aclr1.
- sop_resulta  in  37  signed ax*ay+bx*by.
- res_valid  out  1  result available.
- res_ready  in  1  result accept.
- res_data  out  ACC_W  signed dot-product result.
- res_tag  out  clog2(N_REQ)  requester index.
- res_ovf  out  1  job exceeded 2048 beats.
- busy  out  1  state != IDLE.

Function
REQ-005 FSM states IDLE, ISSUE, DRAIN, DONE; transitions occur only on clk0.
REQ-006 IDLE: any req_valid high -> round-robin grant from (last_grant+1) mod N_REQ, register grant, clear accumulator, beat counter and ovf flag, go to ISSUE; otherwise stay in IDLE.
REQ-007 ISSUE: req_ready[g]=1 only for granted g, all other bits 0; beat accepted when req_valid[g]&req_ready[g]; accepted beat drives sop_* operands the same cycle, and non-accepted cycles drive zero operands.
REQ-008 Shadow valid shift register of depth SOP_LAT tracks accepted beats; when its output stage is 1, acc <= acc + sign-extend(sop_resulta) to ACC_W; two's-complement wrap is permitted.
REQ-009 Accepted beat with req_last[g]=1 -> DRAIN; a requester may deassert req_valid mid-job (bubble), and grant is held until last.
REQ-010 DRAIN: remain until shadow register is all-zero after the final accumulate, then load res_data=acc, res_tag=g, res_ovf, and go to DONE.
REQ-011 DONE: res_valid=1 and outputs held stable until res_ready=1; on handshake, last_grant<=g and FSM returns to IDLE; a new grant may occur no earlier than the next cycle.
REQ-012 Beat counter is 12 bits; a 2049th accepted beat sets ovf sticky for the job and the counter saturates.
REQ-013 sop_ena=3'b111 whenever aclr0_n=1; sop_chainin=0 always; sop_aclr=~aclr0_n combinationally.
REQ-014 Single requester repeatedly valid with other requests pending shall still rotate: after its job, any other pending requester wins next.
REQ-015 res_ready while res_valid=0 shall be ignored.

Reset
REQ-016 aclr0_n low asynchronously forces IDLE, last_grant=N_REQ-1 (first grant goes to requester 0), acc=0, shadow=0, res_valid=0, res_data=0, res_tag=0, res_ovf=0, req_ready=0, busy=0.
REQ-017 Reset mid-job abandons the job with no result emitted; after release, FSM restarts from IDLE.

Structure
REQ-018 Package sop_sched_pkg holds the state enum, operand widths (18/19), SOP result width 37, and the beat-limit constant 2048.
REQ-019 Round-robin selection is one sub-module, sop_rr_arb (request vector, last_grant in; one-hot grant and index out).

Verification
REQ-020 Req0 job of 3 beats (ax,ay,bx,by)=(1,2,3,4),(5,6,7,8),(-1,1,0,0): res_valid with res_data=14+86-1=99, res_tag=0, res_ovf=0.
REQ-021 All four requesters valid from reset: grant order 0,1,2,3,0; no req_ready to non-granted requesters.
REQ-022 Bubbles: req1 job of 2 beats with 4 idle cycles between them -> correct sum, and no extra accumulates from zero-operand cycles.
REQ-023 res_ready held 0 for 10 cycles in DONE -> outputs stable, no new grant, busy=1.
REQ-024 aclr0_n pulsed low mid-ISSUE -> all outputs at reset values, sop_aclr=1 during the pulse, and the next job result is correct.
REQ-025 2049-beat job of (131071,262143,131071,262143) -> res_ovf=1, res_data equals the wrapped 48-bit sum.
